// File: rtl/cofactor_pair_packer_pkg.sv
// Shared types and default widths for the cofactor pair packer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cofactor_pkg;

  localparam int DATA_WIDTH = 4;
  localparam int CNT_WIDTH  = 16;

  // Packer FSM: nothing held, first entry held, output slot occupied.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HALF  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/cofactor_pair_packer_if.sv
// FIFO-side pop port and pair-side valid/ready port of the packer.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the consumer stalls the packer output slot.
interface cofactor_pair_packer_if
  import cofactor_pkg::*;
#(
  parameter int data_width = DATA_WIDTH
);

  logic                    fifo_empty;
  logic [data_width-1:0]   fifo_dout;
  logic                    fifo_rd_en;
  logic [2*data_width-1:0] out_data;
  logic                    out_odd;
  logic                    out_valid;
  logic                    out_ready;

  // Packer side: pops the FIFO and drives the pair stream.
  modport master (
    input  fifo_empty, fifo_dout, out_ready,
    output fifo_rd_en, out_data, out_odd, out_valid
  );

  // Environment side: provides FIFO head and consumes pairs.
  modport slave (
    output fifo_empty, fifo_dout, out_ready,
    input  fifo_rd_en, out_data, out_odd, out_valid
  );

endinterface

// File: rtl/sync_fifo.sv
// Generic single-clock show-ahead FIFO; rd_data is the head whenever empty=0.
// Latency: a write is visible at the head the cycle after it is taken.
// Backpressure: writes are dropped while full, reads are ignored while empty.
module sync_fifo #(
  parameter int width      = 4,
  parameter int depth_log2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [width-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [width-1:0]      rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [depth_log2:0]   count
);

  logic [width-1:0]      mem [2**depth_log2];
  logic [depth_log2-1:0] wr_ptr;
  logic [depth_log2-1:0] rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = count[depth_log2];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (depth_log2)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (depth_log2)'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (depth_log2 + 1)'(1);
        2'b01:   count <= count - (depth_log2 + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/cofactor_pair_packer.sv
// Pops single entries from a show-ahead FIFO and emits them as {second, first} pairs.
// Latency: pair valid 1 cycle after the second entry is popped; 1 pair per 2 cycles.
// Backpressure: out_ready=0 freezes the output slot and stops FIFO pops in S_FULL.
module cofactor_pair_packer
  import cofactor_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int cnt_width  = CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  cofactor_pair_packer_if.master bus,
  input  logic                 flush,
  output logic [cnt_width-1:0] pair_count,
  output logic                 busy
);

  state_t                  state;
  state_t                  state_nxt;
  logic [data_width-1:0]   held;
  logic [data_width-1:0]   held_nxt;
  logic [2*data_width-1:0] data_q;
  logic [2*data_width-1:0] data_nxt;
  logic                    odd_q;
  logic                    odd_nxt;
  logic                    vld_q;
  logic                    vld_nxt;
  logic                    pop;
  logic                    accept;

  // Next-state, pop request and output-slot updates.
  always_comb begin
    state_nxt = state;
    held_nxt  = held;
    data_nxt  = data_q;
    odd_nxt   = odd_q;
    vld_nxt   = vld_q;
    pop       = 1'b0;
    accept    = vld_q & bus.out_ready;
    case (state)
      S_EMPTY: begin
        pop = ~bus.fifo_empty;
        if (pop) begin
          held_nxt  = bus.fifo_dout;
          state_nxt = S_HALF;
        end
      end
      S_HALF: begin
        pop = ~bus.fifo_empty;
        if (pop) begin
          data_nxt  = {bus.fifo_dout, held};
          odd_nxt   = 1'b0;
          vld_nxt   = 1'b1;
          state_nxt = S_FULL;
        end else if (flush) begin
          // FIFO is empty here, so the held entry goes out alone, zero-padded.
          data_nxt  = {{data_width{1'b0}}, held};
          odd_nxt   = 1'b1;
          vld_nxt   = 1'b1;
          state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        pop = ~bus.fifo_empty & bus.out_ready;
        if (accept) begin
          vld_nxt = 1'b0;
          if (pop) begin
            held_nxt  = bus.fifo_dout;
            state_nxt = S_HALF;
          end else begin
            state_nxt = S_EMPTY;
          end
        end
      end
      default: begin
        vld_nxt   = 1'b0;
        state_nxt = S_EMPTY;
      end
    endcase
  end

  // State, held entry and registered output slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_EMPTY;
      held   <= '0;
      data_q <= '0;
      odd_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      held   <= held_nxt;
      data_q <= data_nxt;
      odd_q  <= odd_nxt;
      vld_q  <= vld_nxt;
    end
  end

  // Count pairs taken downstream; wraps naturally at the counter width.
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_count <= '0;
    end else if (accept) begin
      pair_count <= pair_count + cnt_width'(1);
    end
  end

  assign bus.fifo_rd_en = pop & ~rst;
  assign bus.out_data   = data_q;
  assign bus.out_odd    = odd_q;
  assign bus.out_valid  = vld_q;
  assign busy           = (state != S_EMPTY);

endmodule
